// File: rtl/three_bit_serial_adder.sv
// three_bit_serial_adder: bit-serial adder. Two WIDTH-bit operands arrive
// LSB-first on d (A then B), then are summed one bit per clock through a
// single full adder and carry flop. One-shot: reset starts a new transaction.
module three_bit_serial_adder #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Cout,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ADD    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             last;
  logic             s;

  // Parallel operand ports are reserved and intentionally unused.
  logic unused_ab;
  assign unused_ab = ^{A, B};

  assign last = (cnt_q == CW'(WIDTH - 1));

  // State, phase counter, operand/sum shift registers and carry flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state: load A, load B, add bit-serially, then hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    s       = rega_q[0] ^ regb_q[0] ^ cout_q;
    case (state_q)
      LOAD_A: begin
        rega_d = {d, rega_q[WIDTH-1:1]};
        cnt_d  = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = LOAD_B;
      end
      LOAD_B: begin
        regb_d = {d, regb_q[WIDTH-1:1]};
        cnt_d  = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = ADD;
      end
      ADD: begin
        cout_d = (rega_q[0] & regb_q[0]) | (rega_q[0] & cout_q) | (regb_q[0] & cout_q);
        sum_d  = {s, sum_q[WIDTH-1:1]};
        rega_d = rega_q >> 1;
        regb_d = regb_q >> 1;
        cnt_d  = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        // terminal: everything holds until reset
      end
      default: state_d = LOAD_A;
    endcase
  end

  assign q    = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_three_bit_serial_adder.sv
// tb_three_bit_serial_adder: directed bench with a scoreboard queue of
// expected {Cout,q} values, checked by immediate assertions.
module tb_three_bit_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       d;
  logic [2:0] A, B;
  logic       Cout;
  logic [2:0] q;

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;
  logic [3:0]  sb[$];
  logic [3:0]  held;

  three_bit_serial_adder #(.WIDTH(3)) dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .A    (A),
    .B    (B),
    .Cout (Cout),
    .q    (q)
  );

  always #5 clk = ~clk;

  // Expected {Cout,q} after k add edges: low k sum bits sit in the top of q.
  function automatic logic [3:0] exp_add(input logic [2:0] a, input logic [2:0] b, input int k);
    int mask, s, qq, c;
    mask = (1 << k) - 1;
    s    = (a & mask) + (b & mask);
    qq   = ((s & mask) << (3 - k)) & 7;
    c    = (s >> k) & 1;
    return {c[0], qq[2:0]};
  endfunction

  task automatic check(input string tag);
    logic [3:0] exp, got;
    if (sb.size() == 0) begin
      nchecks++;
      nerrors++;
      $error("FAIL %s scoreboard empty got=%b", tag, {Cout, q});
      return;
    end
    exp = sb.pop_front();
    got = {Cout, q};
    nchecks++;
    assert (got === exp) else begin
      nerrors++;
      $error("FAIL %s got Cout,q=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one serial bit with random junk on A/B, sample 1ns after the edge.
  task automatic drive_bit(input logic b);
    d = b;
    A = 3'($urandom_range(0, 7));
    B = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    sb.push_back(4'b0000);
    check(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input int nadd, input string tag);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(4'b0000);
      drive_bit(a[i]);
      check({tag, "_loadA"});
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(4'b0000);
      drive_bit(b[i]);
      check({tag, "_loadB"});
    end
    for (int k = 1; k <= nadd; k++) begin
      sb.push_back(exp_add(a, b, k));
      drive_bit(1'($urandom_range(0, 1)));
      check({tag, "_add"});
    end
  endtask

  task automatic hold_done(input logic [2:0] a, input logic [2:0] b, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sb.push_back(exp_add(a, b, 3));
      drive_bit(~d);
      check({tag, "_hold"});
    end
  endtask

  initial begin
    reset = 1'b1;
    d     = 1'b0;
    A     = '0;
    B     = '0;
    #10;
    sb.push_back(4'b0000);
    check("reset_state");
    reset = 1'b0;

    // A=3 (d=1,1,0), B=4 (d=0,0,1) -> q=111, Cout=0; then DONE hold
    run_txn(3'd3, 3'd4, 3, "t3p4");
    held = {Cout, q};
    sb.push_back(4'b0111);
    check("t3p4_final_const");
    hold_done(3'd3, 3'd4, 5, "t3p4");

    do_reset("reset_before_7p7");
    run_txn(3'd7, 3'd7, 3, "t7p7");
    hold_done(3'd7, 3'd7, 2, "t7p7");

    do_reset("reset_before_5p6");
    run_txn(3'd5, 3'd6, 3, "t5p6");
    sb.push_back(4'b1011);
    check("t5p6_final_const");

    do_reset("reset_before_0p0");
    run_txn(3'd0, 3'd0, 3, "t0p0");
    hold_done(3'd0, 3'd0, 1, "t0p0");

    // Abort mid-ADD (after the 7th edge), then reload 2+1
    do_reset("reset_before_abort");
    run_txn(3'd6, 3'd7, 1, "abort");
    do_reset("reset_mid_add");
    run_txn(3'd2, 3'd1, 3, "t2p1");
    sb.push_back(4'b0011);
    check("t2p1_final_const");
    hold_done(3'd2, 3'd1, 2, "t2p1");

    // A few random operand pairs
    for (int t = 0; t < 4; t++) begin
      logic [2:0] ra, rb;
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      do_reset("reset_rand");
      run_txn(ra, rb, 3, "rand");
      hold_done(ra, rb, 1, "rand");
    end

    if (sb.size() != 0) begin
      nchecks++;
      nerrors++;
      $error("FAIL scoreboard_drain leftover=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
